// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU and its multiplier.
package alu_pkg;

  // Opcode encoding presented on the op port.
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_t;

  // Control states: idle, multiply in progress, result presented.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit positions of the status flags inside the packed flag vector.
  localparam int FLAG_Z    = 0;
  localparam int FLAG_C    = 1;
  localparam int FLAG_V    = 2;
  localparam int FLAG_N    = 3;
  localparam int NUM_FLAGS = 4;

  // Assemble the packed flag vector from individual flag bits.
  function automatic logic [NUM_FLAGS-1:0] pack_flags(input logic z, input logic c,
                                                      input logic v, input logic n);
    logic [NUM_FLAGS-1:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier. The start cycle loads the operands and
// performs the first partial-product step; WIDTH-1 further steps follow,
// one per clock. done pulses for one cycle after the final step, with the
// full 2*WIDTH product on prod.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int SHW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [SHW-1:0]     cnt;

  // Iteration engine: multiplicand shifts left, multiplier shifts right,
  // accumulator adds the multiplicand whenever the multiplier LSB is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
        mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
        mplier <= b >> 1;
        cnt    <= SHW'(1);
        busy   <= 1'b1;
      end else if (busy) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + SHW'(1);
        if (cnt == SHW'(WIDTH-1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign prod = acc;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready on both sides and a multi-cycle multiply.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The input side is ready when idle, or when a result is
// being handed off in the same cycle, so single-cycle ops stream at one per
// clock. The output side holds result and flags stable while out_valid is
// high and out_ready is low. Only one operation is in flight at a time.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_t state;
  state_t state_nxt;

  op_t                  op_in;
  logic                 accept;
  logic                 mul_start;
  logic                 mul_busy;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_prod;

  logic [SHW-1:0]       sh;
  logic [WIDTH:0]       sum_w;
  logic [WIDTH:0]       diff_w;
  logic [WIDTH:0]       shl_w;
  logic [WIDTH:0]       shr_w;

  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic                 alu_v;
  logic [NUM_FLAGS-1:0] alu_flags;

  logic [WIDTH-1:0]     mul_res;
  logic [NUM_FLAGS-1:0] mul_flags;

  logic [WIDTH-1:0]     result_q;
  logic [NUM_FLAGS-1:0] flags_q;

  assign op_in     = op_t'(op);
  assign in_ready  = ((state == ST_IDLE) || ((state == ST_DONE) && out_ready)) && !mul_busy;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op_in == OP_MUL);
  assign out_valid = (state == ST_DONE);

  // Carry, borrow and shift-out fall out of the extra top/bottom bit.
  assign sh     = b[SHW-1:0];
  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};
  assign shl_w  = {1'b0, a} << sh;
  assign shr_w  = {a, 1'b0} >> sh;

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // Single-cycle datapath: result, carry and overflow for non-multiply ops.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_in)
      OP_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff_w[WIDTH-1:0];
        alu_c   = diff_w[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (diff_w[MSB] != a[MSB]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
    endcase
    alu_flags = pack_flags(alu_res == '0, alu_c, alu_v, alu_res[MSB]);
  end

  // Multiply flags: carry marks a product that does not fit in WIDTH bits.
  always_comb begin
    mul_res   = mul_prod[WIDTH-1:0];
    mul_flags = pack_flags(mul_res == '0, |mul_prod[2*WIDTH-1:WIDTH], 1'b0, mul_res[MSB]);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept from IDLE or from DONE during hand-off.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = mul_start ? ST_MUL : ST_DONE;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          if (accept) begin
            state_nxt = mul_start ? ST_MUL : ST_DONE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output registers: load on a single-cycle accept or on multiply completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (accept && !mul_start) begin
      result_q <= alu_res;
      flags_q  <= alu_flags;
    end else if ((state == ST_MUL) && mul_done) begin
      result_q <= mul_res;
      flags_q  <= mul_flags;
    end
  end

  assign result = result_q;
  assign flag_z = flags_q[FLAG_Z];
  assign flag_c = flags_q[FLAG_C];
  assign flag_v = flags_q[FLAG_V];
  assign flag_n = flags_q[FLAG_N];

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed vectors, backpressure, reset abort and a
// randomized run, all checked by a scoreboard fed from an arithmetic model.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int RW = W + 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         flag_z, flag_c, flag_v, flag_n;

  logic         rand_ready = 1'b0;
  logic         forced_ready = 1'b0;

  logic [RW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_n    (flag_n)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Plain integer arithmetic; signed overflow judged by range of the true sum.
  function automatic logic [RW-1:0] model(input logic [2:0] o, input logic [W-1:0] av,
                                          input logic [W-1:0] bv);
    longint full = longint'(1) << W;
    longint half = full >> 1;
    longint ua = longint'(av);
    longint ub = longint'(bv);
    longint sa = (ua >= half) ? ua - full : ua;
    longint sb = (ub >= half) ? ub - full : ub;
    longint s  = ub % W;
    longint r  = 0;
    longint c  = 0;
    longint v  = 0;
    logic [W-1:0] rv;
    logic [3:0]   f;
    case (o)
      3'd0: begin
        r = (ua + ub) % full;
        c = ((ua + ub) >= full) ? 1 : 0;
        v = ((sa + sb) >= half || (sa + sb) < -half) ? 1 : 0;
      end
      3'd1: begin
        r = (ua - ub + full) % full;
        c = (ua < ub) ? 1 : 0;
        v = ((sa - sb) >= half || (sa - sb) < -half) ? 1 : 0;
      end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: begin
        r = (ua << s) % full;
        c = (s == 0) ? 0 : ((ua >> (W - s)) & 1);
      end
      3'd6: begin
        r = ua >> s;
        c = (s == 0) ? 0 : ((ua >> (s - 1)) & 1);
      end
      default: begin
        r = (ua * ub) % full;
        c = ((ua * ub) >= full) ? 1 : 0;
      end
    endcase
    rv = W'(r);
    f = '0;
    f[FLAG_Z] = (r == 0);
    f[FLAG_C] = (c != 0);
    f[FLAG_V] = (v != 0);
    f[FLAG_N] = (r >= half);
    return {rv, f};
  endfunction

  function automatic logic [RW-1:0] dut_out();
    logic [3:0] f;
    f = '0;
    f[FLAG_Z] = flag_z;
    f[FLAG_C] = flag_c;
    f[FLAG_V] = flag_v;
    f[FLAG_N] = flag_n;
    return {result, f};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- out_ready driver ----------------
  always begin
    @(negedge clk);
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
  end

  // ---------------- monitor / scoreboard ----------------
  // Compares every cycle a result is presented; pops when it is taken.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(dut_out()), 64'hDEAD);
      end else begin
        check("result_flags", 64'(dut_out()), 64'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at a falling edge with in_valid low.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    int waited = 0;
    bit took = 0;
    op = o; a = av; b = bv; in_valid = 1'b1;
    while (!took && waited < 200) begin
      #2;
      if (in_ready) begin
        took = 1;
        exp_q.push_back(model(o, av, bv));
      end
      @(negedge clk);
      waited++;
    end
    in_valid = 1'b0;
    if (!took) check("issue_timeout", 64'd0, 64'd1);
  endtask

  // Issues one op and measures cycles from acceptance to out_valid.
  task automatic timed(input string name, input logic [2:0] o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input int exp_lat);
    int lat = 1;
    bit got = 0;
    issue(o, av, bv);
    while (!got && lat < 40) begin
      #2;
      if (out_valid) got = 1;
      else begin
        check({name, "_in_ready_low"}, 64'(in_ready), 64'd0);
        @(negedge clk);
        lat++;
      end
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int wait_cnt;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_outputs", 64'(dut_out()), 64'd0);
    @(negedge clk);

    forced_ready = 1'b1;
    @(negedge clk);
    timed("add_carry",    3'd0, 8'd200, 8'd100, 1);
    timed("add_ovf",      3'd0, 8'd100, 8'd100, 1);
    timed("sub_5_3",      3'd1, 8'd5,   8'd3,   1);
    timed("sub_3_5",      3'd1, 8'd3,   8'd5,   1);
    timed("sub_80_1",     3'd1, 8'h80,  8'd1,   1);
    timed("sub_7_7",      3'd1, 8'd7,   8'd7,   1);
    timed("mul_12_11",    3'd7, 8'd12,  8'd11,  W + 1);
    timed("mul_20_20",    3'd7, 8'd20,  8'd20,  W + 1);
    timed("shl_81_1",     3'd5, 8'h81,  8'd1,   1);
    timed("shr_81_0",     3'd6, 8'h81,  8'd0,   1);
    timed("shr_81_9",     3'd6, 8'h81,  8'd9,   1);
    timed("xor",          3'd4, 8'hA5,  8'hFF,  1);

    // Backpressure followed by a hand-off with a simultaneous accept.
    forced_ready = 1'b0;
    issue(3'd0, 8'h33, 8'h44);
    #2;
    check("bp_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    forced_ready = 1'b1;
    issue(3'd2, 8'hF0, 8'h3C);
    #2;
    check("no_gap_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    @(negedge clk);

    // Reset in the middle of a multiply aborts it.
    issue(3'd7, 8'd13, 8'd17);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_outputs", 64'(dut_out()), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("rst_release_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    timed("or_after_reset", 3'd3, 8'h0A, 8'h05, 1);

    // Randomized traffic with random consumer backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Drain.
    rand_ready = 1'b0;
    forced_ready = 1'b1;
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Width is set by WIDTH. Eight opcodes, including a multi-cycle shift-add multiply.
- Produces status flags and uses valid/ready handshakes on both input and output.
- Sits between an operand-issue stage and a result consumer; holds one operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width in bits; power of two, >= 4
- SHW, $clog2(WIDTH), derived (localparam); shift-amount width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (shift amount = b[SHW-1:0] for shifts)
- op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  operation result
- flag_z  out  1  result == 0
- flag_c  out  1  carry/borrow/shift-out/mul-overflow
- flag_v  out  1  signed overflow (ADD/SUB only)
- flag_n  out  1  result[WIDTH-1]

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE; out_valid=0; result=0; all flags=0.
  - in_ready is 1 after release.
  - Reset mid-MUL or mid-DONE aborts the operation; the result is discarded.
- States: IDLE, MUL, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept: an operation is accepted when in_valid && in_ready. a, b and op are captured that cycle.
- Non-MUL op accepted:
  - Next state is DONE; out_valid=1 on the next cycle (latency 1).
  - result and flags are registered.
- MUL accepted:
  - Enter MUL; the sub-module runs exactly WIDTH iterations, then the block enters DONE.
  - out_valid rises WIDTH+1 cycles after acceptance.
- DONE:
  - out_valid=1; result and flags held stable while out_ready=0.
  - out_ready=1 with no new accept: go to IDLE, out_valid=0 next cycle.
  - out_ready=1 with a simultaneous accept: take the new operation and follow the rules above. No bubble for non-MUL ops, giving 1 op/cycle throughput.
- in_valid in MUL is ignored (in_ready=0); the operands must be held by the source.
- Arithmetic:
  - ADD: result = (a+b) mod 2^WIDTH; C = carry-out; V = operand signs equal and result sign differs.
  - SUB: result = (a-b) mod 2^WIDTH; C = borrow (1 iff a<b unsigned); V = operand signs differ and result sign differs from a.
  - AND/OR/XOR: C=0, V=0.
  - SHL/SHR: logical; amount s = b[SHW-1:0]. C = last bit shifted out (a[WIDTH-s] for SHL, a[s-1] for SHR). s=0 gives result=a, C=0. V=0.
  - MUL: unsigned; result = low WIDTH bits of the 2*WIDTH product; C=1 iff the high WIDTH bits are nonzero; V=0.
- Z and N are derived from result for every op.
- Unused high bits of b are ignored for shifts; there are no illegal opcodes.

Decomposition:
- Package alu_pkg:
  - op enum (OP_ADD..OP_MUL, 3 bits)
  - state enum (ST_IDLE, ST_MUL, ST_DONE)
  - flag bit-index constants (FLAG_Z, FLAG_C, FLAG_V, FLAG_N)
- Sub-module alu_mul_seq: shift-add multiplier.
  - Parametrised WIDTH; ports start/a/b in, busy/done/prod[2*WIDTH-1:0] out.
  - Same clk/rst_n.
  - done pulses one cycle after the final iteration.
- The top level holds the FSM, handshake logic, single-cycle datapath and flag logic.

Test Plan:
- Accept/ADD latency: WIDTH=8, ADD a=200 b=100 -> one cycle later out_valid=1, result=44, C=1, V=0, Z=0, N=0.
- ADD overflow: a=100 b=100 -> result=200, V=1, N=1, C=0.
- SUB cases:
  - a=5 b=3 -> 2, C=0.
  - a=3 b=5 -> 254, C=1, N=1.
  - a=0x80 b=1 -> 0x7F, V=1.
  - a=7 b=7 -> 0, Z=1.
- MUL: a=12 b=11 -> out_valid exactly 9 cycles after accept, result=132, C=0, in_ready=0 throughout. Then a=20 b=20 -> result=144, C=1.
- Shifts:
  - SHL a=0x81 b=1 -> 0x02, C=1.
  - SHR a=0x81 b=0 -> 0x81, C=0.
  - SHR a=0x81 b=9 (s=1) -> 0x40, C=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE -> result and flags stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 AND a=0xF0 b=0x3C -> next cycle result=0x30, out_valid stays 1 with no gap.
- Reset: assert rst_n=0 mid-MUL (cycle 4) -> out_valid=0, result=0, flags=0 immediately. After release, in_ready=1 and OR a=0x0A b=0x05 returns 0x0F.
